// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between
// the ALU writeback (A) and the load writeback (B), with a one-cycle registered path.
module rf_write_arbiter #(
    parameter int W          = 8,
    parameter int A          = 3,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Hold,
    input  logic              AValid,
    input  logic [A-1:0]      AAddr,
    input  logic [W-1:0]      AData,
    output logic              AReady,
    input  logic              BValid,
    input  logic [A-1:0]      BAddr,
    input  logic [W-1:0]      BData,
    output logic              BReady,
    output logic              RfWriteEn,
    output logic [A-1:0]      RfWaddr,
    output logic [W-1:0]      RfData,
    output logic [2**A-1:0]   Pending,
    output logic              Collision
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e         last_grant_q, last_grant_d;
    logic           we_q, we_d;
    logic [A-1:0]   waddr_q, waddr_d;
    logic [W-1:0]   data_q, data_d;
    logic           collision_q, collision_d;

    // Readys depend only on Valids, Hold and LastGrant, never on Addr/Data.
    assign AReady = !Hold && AValid && (!BValid || (last_grant_q == GRANT_B));
    assign BReady = !Hold && BValid && (!AValid || (last_grant_q == GRANT_A));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        data_d       = data_q;
        collision_d  = AValid && BValid && (AAddr == BAddr) && !Hold;

        if (AReady) begin
            last_grant_d = GRANT_A;
            waddr_d      = AAddr;
            data_d       = AData;
            we_d         = !(PROTECT_R0 && (AAddr == '0));
        end else if (BReady) begin
            last_grant_d = GRANT_B;
            waddr_d      = BAddr;
            data_d       = BData;
            we_d         = !(PROTECT_R0 && (BAddr == '0));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_q <= GRANT_B;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            collision_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            collision_q  <= collision_d;
        end
    end

    assign RfWriteEn = we_q;
    assign RfWaddr   = waddr_q;
    assign RfData    = data_q;
    assign Collision = collision_q;

    always_comb begin
        Pending = '0;
        if (we_q) Pending[waddr_q] = 1'b1;
    end

    a_one_grant: assert property (@(posedge Clk) disable iff (!Reset_n) !(AReady && BReady));
    a_ready_needs_valid: assert property (@(posedge Clk) disable iff (!Reset_n)
        (!AReady || AValid) && (!BReady || BValid));

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load data from data memory).
- Uses round-robin arbitration with a valid/ready handshake on each requester.
- Registers the winning request and drives the register file's WriteEn/Waddr/DataIn one cycle later.
- Also flags same-address collisions and publishes a one-hot pending-write vector for hazard logic.

Parameters:
W, 8, data path width (matches register-file word width)
A, 3, register address width; register count is 2**A
PROTECT_R0, 0, 1 = writes to address 0 are accepted but never reach the register file

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
Hold  input  1  freeze: no grants while high
AValid  input  1  requester A has a write
AAddr  input  A  requester A destination register
AData  input  W  requester A write data
AReady  output  1  A granted this cycle (transfer = AValid & AReady)
BValid  input  1  requester B has a write
BAddr  input  A  requester B destination register
BData  input  W  requester B write data
BReady  output  1  B granted this cycle
RfWriteEn  output  1  to register-file WriteEn
RfWaddr  output  A  to register-file Waddr
RfData  output  W  to register-file DataIn
Pending  output  2**A  one-hot of RfWaddr when RfWriteEn=1, else all zero
Collision  output  1  one-cycle pulse: previous cycle had both requesters valid with the same address

Behaviour:
- Reset (Reset_n=0, asynchronous): RfWriteEn=0, RfWaddr=0, RfData=0, Collision=0, Pending=0, LastGrant=B (so A wins the first contention).
- Reset mid-operation: any write held in the output register is discarded, not performed.
- Readys are combinational from Valids, Hold and LastGrant; never combinational from Addr/Data:
  - Hold=1: AReady=BReady=0.
  - Only one requester valid: that requester gets Ready=1.
  - Both valid: the requester not equal to LastGrant gets Ready=1; the other gets 0.
  - AReady and BReady are never both 1; Ready=0 whenever the matching Valid=0.
- Requester rule: Valid, Addr and Data stay stable until the transfer. Dropping Valid before the transfer is legal and simply withdraws the request.
- Transfer in cycle t: at the closing edge of t, RfWaddr<=winner Addr, RfData<=winner Data, LastGrant<=winner.
  - RfWriteEn<=1, except RfWriteEn<=0 when PROTECT_R0=1 and Addr=0. The request is still consumed (Ready=1).
  - Latency: requester handshake to register-file write is exactly one cycle. The register file captures at the end of cycle t+1.
- No transfer in cycle t: RfWriteEn<=0; RfWaddr/RfData hold their previous values; LastGrant holds.
- Throughput: one write per cycle. Back-to-back transfers from the same requester are allowed when the other is idle.
- Collision: registered. Collision<=AValid & BValid & (AAddr==BAddr) & !Hold.
  - The loser remains valid and writes in the following transfer, so the later write wins.
  - Ordering between requesters is not guaranteed; upstream control uses Collision/Pending to stall.
- Pending: combinational decode of the output register (bit RfWaddr set iff RfWriteEn=1).
- Hold asserted mid-stream: the grant for that cycle is suppressed; the already-registered write still completes in the current cycle; LastGrant is unchanged.
- Starvation bound: with both valid continuously, each requester is granted at least every second cycle.

Test Plan:
- Reset: Reset_n=0 asynchronously mid-cycle with RfWriteEn=1 -> all outputs 0 immediately; after release, A=(3,0x5A) alone -> AReady=1 that cycle, next cycle RfWriteEn=1, RfWaddr=3, RfData=0x5A, Pending=0b00001000.
- Contention: A=(1,0x11), B=(2,0x22) valid 4 cycles after reset -> grants A,B,A,B; register file ends r1=0x11, r2=0x22; Collision stays 0.
- Collision: A=(5,0xAA), B=(5,0xBB) both valid, LastGrant=B -> A granted, Collision=1 next cycle; B granted the following cycle; r5=0xBB afterwards.
- Hold: B=(4,0x44) valid with Hold=1 for 3 cycles -> BReady=0, RfWriteEn=0 throughout; Hold drops -> BReady=1, next cycle write r4=0x44.
- PROTECT_R0=1: A=(0,0xFF) -> AReady=1, next cycle RfWriteEn=0, r0 unchanged, Pending=0; same stimulus with PROTECT_R0=0 -> r0=0xFF.
- Stream: B alone, addresses 0..7 with data 0x80+addr on consecutive cycles -> eight back-to-back writes, RfWriteEn high 8 cycles, no bubbles.
